// File: rtl/prng_pkg.sv
// ---------------------------------------------------------------------------
// | prng_pkg : constants, step/fix-up helpers and FSM encoding for LFSR113   |
// | Revision : 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

package prng_pkg;

  localparam logic [31:0] C_DEFAULT_SEED = 32'd987654321;
  localparam logic [31:0] C_GOLD         = 32'h9E3779B9;

  localparam logic [31:0] C_MASK1 = 32'hFFFFFFFE;
  localparam logic [31:0] C_MASK2 = 32'hFFFFFFF8;
  localparam logic [31:0] C_MASK3 = 32'hFFFFFFF0;
  localparam logic [31:0] C_MASK4 = 32'hFFFFFF80;

  // Per component: mask shift, feedback shift, feedback right shift
  localparam int unsigned C_SH1A = 18, C_SH1B = 6,  C_SH1C = 13;
  localparam int unsigned C_SH2A = 2,  C_SH2B = 2,  C_SH2C = 27;
  localparam int unsigned C_SH3A = 7,  C_SH3B = 13, C_SH3C = 21;
  localparam int unsigned C_SH4A = 13, C_SH4B = 3,  C_SH4C = 12;

  localparam logic [31:0] C_MIN1 = 32'd2;
  localparam logic [31:0] C_MIN2 = 32'd8;
  localparam logic [31:0] C_MIN3 = 32'd16;
  localparam logic [31:0] C_MIN4 = 32'd128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  function automatic logic [31:0] taus_step(input logic [31:0] z, input logic [31:0] mask,
                                            input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    return ((z & mask) << a) ^ (((z << b) ^ z) >> c);
  endfunction

  // A component below its minimum would collapse to a short cycle
  function automatic logic [31:0] fixup(input logic [31:0] v, input logic [31:0] min);
    return (v < min) ? v + min : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/taus113_lane.sv
// ---------------------------------------------------------------------------
// | taus113_lane : one channel of the combined Tausworthe generator          |
// | Revision     : 1.0                                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module taus113_lane
  import prng_pkg::*;
#(
  parameter int          CH_IDX       = 0,
  parameter logic [31:0] DEFAULT_SEED = C_DEFAULT_SEED
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] word
);

  localparam logic [31:0] C_OFF1 = C_GOLD * 32'(4 * CH_IDX + 1);
  localparam logic [31:0] C_OFF2 = C_GOLD * 32'(4 * CH_IDX + 2);
  localparam logic [31:0] C_OFF3 = C_GOLD * 32'(4 * CH_IDX + 3);
  localparam logic [31:0] C_OFF4 = C_GOLD * 32'(4 * CH_IDX + 4);

  logic [31:0] r_z1, r_z2, r_z3, r_z4;
  logic [31:0] w_n1, w_n2, w_n3, w_n4;

  assign w_n1 = taus_step(r_z1, C_MASK1, C_SH1A, C_SH1B, C_SH1C);
  assign w_n2 = taus_step(r_z2, C_MASK2, C_SH2A, C_SH2B, C_SH2C);
  assign w_n3 = taus_step(r_z3, C_MASK3, C_SH3A, C_SH3B, C_SH3C);
  assign w_n4 = taus_step(r_z4, C_MASK4, C_SH4A, C_SH4B, C_SH4C);

  // Output word is taken from the post-step components
  assign word = w_n1 ^ w_n2 ^ w_n3 ^ w_n4;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_z1 <= fixup(DEFAULT_SEED + C_OFF1, C_MIN1);
      r_z2 <= fixup(DEFAULT_SEED + C_OFF2, C_MIN2);
      r_z3 <= fixup(DEFAULT_SEED + C_OFF3, C_MIN3);
      r_z4 <= fixup(DEFAULT_SEED + C_OFF4, C_MIN4);
    end else if (load) begin
      r_z1 <= fixup(seed + C_OFF1, C_MIN1);
      r_z2 <= fixup(seed + C_OFF2, C_MIN2);
      r_z3 <= fixup(seed + C_OFF3, C_MIN3);
      r_z4 <= fixup(seed + C_OFF4, C_MIN4);
    end else if (step) begin
      r_z1 <= w_n1;
      r_z2 <= w_n2;
      r_z3 <= w_n3;
      r_z4 <= w_n4;
    end
  end

endmodule

`default_nettype wire

// File: rtl/taus113_prng_mc.sv
// ---------------------------------------------------------------------------
// | taus113_prng_mc : multi-channel LFSR113 generator, seed/warm-up/handshake |
// | Revision        : 1.0                                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module taus113_prng_mc
  import prng_pkg::*;
#(
  parameter int          N_CH         = 2,
  parameter int          WARMUP       = 10,
  parameter logic [31:0] DEFAULT_SEED = 32'd987654321
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 enable_p,
  input  logic                 seed_valid_i,
  input  logic [31:0]          seed_i,
  output logic                 seed_ready_o,
  output logic [32*N_CH-1:0]   prng_o,
  output logic                 prng_valid_o,
  input  logic                 prng_ready_i,
  output logic [31:0]          prng_cnt_o,
  output logic [1:0]           state_o
);

  localparam logic [7:0] C_WARMUP = 8'(WARMUP);
  localparam state_t     C_ENTRY  = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_wcnt, w_wcnt_nxt;
  logic                w_load, w_step, w_run_step, w_seed_hs, w_xfer;
  logic [32*N_CH-1:0]  w_words;

  assign seed_ready_o = (r_state != ST_WARMUP);
  assign w_seed_hs    = seed_valid_i && seed_ready_o;
  assign w_xfer       = prng_valid_o && prng_ready_i;
  assign state_o      = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_run_step  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_seed_hs || enable_p) begin
          w_load      = w_seed_hs;
          w_state_nxt = C_ENTRY;
          w_wcnt_nxt  = C_WARMUP;
        end
      end
      ST_WARMUP: begin
        w_step     = 1'b1;
        w_wcnt_nxt = r_wcnt - 8'd1;
        if (r_wcnt == 8'd1) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A reseed wins over a step in the same cycle
        if (w_seed_hs) begin
          w_load      = 1'b1;
          w_state_nxt = C_ENTRY;
          w_wcnt_nxt  = C_WARMUP;
        end else if (enable_p && (!prng_valid_o || prng_ready_i)) begin
          w_step     = 1'b1;
          w_run_step = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_wcnt  <= C_WARMUP;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    taus113_lane #(
      .CH_IDX       (c),
      .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lane (
      .CLK   (CLK),
      .reset (reset),
      .load  (w_load),
      .step  (w_step),
      .seed  (seed_i),
      .word  (w_words[32*c +: 32])
    );
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      prng_o       <= '0;
      prng_valid_o <= 1'b0;
      prng_cnt_o   <= '0;
    end else begin
      if (w_xfer) prng_cnt_o <= prng_cnt_o + 32'd1;
      if (w_run_step) begin
        prng_o       <= w_words;
        prng_valid_o <= 1'b1;
      end else if (w_load || w_xfer) begin
        prng_valid_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_taus113_prng_mc.sv
// ---------------------------------------------------------------------------
// | tb_taus113_prng_mc : directed self-checking bench against an LFSR113 model |
// | Revision           : 1.0                                                   |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_taus113_prng_mc;

  localparam int N_CH   = 2;
  localparam int WARMUP = 10;
  localparam logic [31:0] SEED_DEF = 32'd987654321;

  logic              CLK = 1'b0;
  logic              reset, enable_p, seed_valid_i, prng_ready_i;
  logic [31:0]       seed_i;
  logic              seed_ready_o, prng_valid_o;
  logic [32*N_CH-1:0] prng_o;
  logic [31:0]       prng_cnt_o;
  logic [1:0]        state_o;

  // Second instance: single channel, no warm-up phase
  logic              seed_valid_b = 1'b0, prng_ready_b = 1'b1;
  logic [31:0]       seed_b = 32'd0;
  logic              seed_ready_b, prng_valid_b;
  logic [31:0]       prng_b, prng_cnt_b;
  logic [1:0]        state_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  taus113_prng_mc #(.N_CH(N_CH), .WARMUP(WARMUP), .DEFAULT_SEED(SEED_DEF)) dut (
    .CLK(CLK), .reset(reset), .enable_p(enable_p), .seed_valid_i(seed_valid_i),
    .seed_i(seed_i), .seed_ready_o(seed_ready_o), .prng_o(prng_o),
    .prng_valid_o(prng_valid_o), .prng_ready_i(prng_ready_i),
    .prng_cnt_o(prng_cnt_o), .state_o(state_o)
  );

  taus113_prng_mc #(.N_CH(1), .WARMUP(0), .DEFAULT_SEED(SEED_DEF)) dut0 (
    .CLK(CLK), .reset(reset), .enable_p(enable_p), .seed_valid_i(seed_valid_b),
    .seed_i(seed_b), .seed_ready_o(seed_ready_b), .prng_o(prng_b),
    .prng_valid_o(prng_valid_b), .prng_ready_i(prng_ready_b),
    .prng_cnt_o(prng_cnt_b), .state_o(state_b)
  );

  // Golden model written straight from the LFSR113 recurrences
  logic [31:0] mz [N_CH][4];

  function automatic logic [31:0] m_expand(input logic [31:0] s, input int c, input int k);
    logic [31:0] mult, v, mn;
    mult = 32'(4 * c + k + 1);
    v    = s + 32'h9E3779B9 * mult;
    case (k)
      0:       mn = 32'd2;
      1:       mn = 32'd8;
      2:       mn = 32'd16;
      default: mn = 32'd128;
    endcase
    if (v < mn) v = v + mn;
    return v;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] z, input int k);
    case (k)
      0:       return ((z & 32'hFFFFFFFE) << 18) ^ (((z << 6)  ^ z) >> 13);
      1:       return ((z & 32'hFFFFFFF8) << 2)  ^ (((z << 2)  ^ z) >> 27);
      2:       return ((z & 32'hFFFFFFF0) << 7)  ^ (((z << 13) ^ z) >> 21);
      default: return ((z & 32'hFFFFFF80) << 13) ^ (((z << 3)  ^ z) >> 12);
    endcase
  endfunction

  task automatic m_seed(input logic [31:0] s);
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < 4; k++) mz[c][k] = m_expand(s, c, k);
  endtask

  task automatic m_next(output logic [32*N_CH-1:0] w);
    w = '0;
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < 4; k++) begin
        mz[c][k] = m_step(mz[c][k], k);
        w[32*c +: 32] = w[32*c +: 32] ^ mz[c][k];
      end
  endtask

  task automatic m_skip(input int n);
    logic [32*N_CH-1:0] d;
    for (int i = 0; i < n; i++) m_next(d);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_prng"},  64'(prng_o), 64'd0);
    chk({tag, "_valid"}, 64'(prng_valid_o), 64'd0);
    chk({tag, "_cnt"},   64'(prng_cnt_o), 64'd0);
    chk({tag, "_sready"}, 64'(seed_ready_o), 64'd1);
    chk({tag, "_state"}, 64'(state_o), 64'd0);
  endtask

  logic [32*N_CH-1:0] exp_w, first_w;
  logic [31:0]        exp_cnt;

  initial begin
    reset = 1'b1; enable_p = 1'b0; seed_valid_i = 1'b0; seed_i = '0; prng_ready_i = 1'b1;
    repeat (2) tick();
    chk_reset("rst");

    m_seed(SEED_DEF);
    m_next(first_w);
    m_seed(SEED_DEF);
    m_skip(WARMUP);

    // Release reset with enable high: edge 1 enters WARMUP
    reset = 1'b0; enable_p = 1'b1;
    tick();
    chk("e1_state", 64'(state_o), 64'd1);
    chk("e1_sready", 64'(seed_ready_o), 64'd0);
    chk("w0_state", 64'(state_b), 64'd2);
    for (int e = 2; e <= 11; e++) begin
      tick();
      chk("warm_valid", 64'(prng_valid_o), 64'd0);
      if (e == 2) chk("w0_word", 64'(prng_b), 64'(first_w[31:0]));
    end
    chk("e11_state", 64'(state_o), 64'd2);

    tick();
    m_next(exp_w);
    exp_cnt = 0;
    chk("e12_valid", 64'(prng_valid_o), 64'd1);
    chk("e12_word", 64'(prng_o), 64'(exp_w));
    chk("e12_cnt", 64'(prng_cnt_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      m_next(exp_w);
      exp_cnt++;
      chk("stream_word", 64'(prng_o), 64'(exp_w));
      chk("stream_cnt", 64'(prng_cnt_o), 64'(exp_cnt));
    end

    // Back-pressure: five stalled cycles
    prng_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_word", 64'(prng_o), 64'(exp_w));
      chk("bp_cnt", 64'(prng_cnt_o), 64'(exp_cnt));
      chk("bp_valid", 64'(prng_valid_o), 64'd1);
    end
    prng_ready_i = 1'b1;
    tick();
    m_next(exp_w);
    exp_cnt++;
    chk("bp_resume_word", 64'(prng_o), 64'(exp_w));
    chk("bp_resume_cnt", 64'(prng_cnt_o), 64'(exp_cnt));

    // enable low: pending word held, then taken, then stream resumes
    enable_p = 1'b0; prng_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_hold_word", 64'(prng_o), 64'(exp_w));
      chk("en_hold_valid", 64'(prng_valid_o), 64'd1);
    end
    prng_ready_i = 1'b1;
    tick();
    exp_cnt++;
    chk("en_taken_valid", 64'(prng_valid_o), 64'd0);
    chk("en_taken_cnt", 64'(prng_cnt_o), 64'(exp_cnt));
    enable_p = 1'b1;
    tick();
    m_next(exp_w);
    chk("en_resume_word", 64'(prng_o), 64'(exp_w));
    chk("en_resume_cnt", 64'(prng_cnt_o), 64'(exp_cnt));
    tick();
    m_next(exp_w);
    exp_cnt++;
    chk("en_next_word", 64'(prng_o), 64'(exp_w));

    // Reseed with 0 in RUN; the transfer at the accept edge counts
    seed_valid_i = 1'b1; seed_i = 32'd0;
    tick();
    seed_valid_i = 1'b0;
    exp_cnt++;
    chk("s0_valid", 64'(prng_valid_o), 64'd0);
    chk("s0_state", 64'(state_o), 64'd1);
    chk("s0_cnt", 64'(prng_cnt_o), 64'(exp_cnt));
    chk("s0_z1", 64'(dut.g_lane[0].u_lane.r_z1), 64'h9E3779B9);
    chk("s0_z2", 64'(dut.g_lane[0].u_lane.r_z2), 64'h3C6EF372);
    chk("s0_z3", 64'(dut.g_lane[0].u_lane.r_z3), 64'hDAA66D2B);
    chk("s0_z4", 64'(dut.g_lane[0].u_lane.r_z4), 64'h78DDE6E4);
    m_seed(32'd0);
    m_skip(WARMUP);
    repeat (WARMUP) tick();
    chk("s0_run_state", 64'(state_o), 64'd2);
    chk("s0_run_valid", 64'(prng_valid_o), 64'd0);
    tick();
    m_next(exp_w);
    chk("s0_word1", 64'(prng_o), 64'(exp_w));
    tick();
    m_next(exp_w);
    exp_cnt++;
    chk("s0_word2", 64'(prng_o), 64'(exp_w));
    chk("s0_cnt2", 64'(prng_cnt_o), 64'(exp_cnt));

    // Seed that drives channel 0 z1 to zero, forcing the fix-up
    seed_valid_i = 1'b1; seed_i = 32'h61C88647;
    tick();
    seed_valid_i = 1'b0;
    exp_cnt++;
    chk("fx_z1", 64'(dut.g_lane[0].u_lane.r_z1), 64'd2);
    chk("fx_cnt", 64'(prng_cnt_o), 64'(exp_cnt));
    m_seed(32'h61C88647);
    m_skip(WARMUP);
    repeat (WARMUP + 1) tick();
    m_next(exp_w);
    chk("fx_word1", 64'(prng_o), 64'(exp_w));
    tick();
    m_next(exp_w);
    chk("fx_word2", 64'(prng_o), 64'(exp_w));

    // Reset in the middle of WARMUP
    seed_valid_i = 1'b1; seed_i = 32'd12345;
    tick();
    seed_valid_i = 1'b0;
    repeat (3) tick();
    chk("mw_state_pre", 64'(state_o), 64'd1);
    reset = 1'b1;
    tick();
    chk_reset("rst_warm");
    reset = 1'b0;

    // Restart from the default seed, then reset in the middle of RUN
    m_seed(SEED_DEF);
    m_skip(WARMUP);
    repeat (WARMUP + 2) tick();
    m_next(exp_w);
    chk("rs_word1", 64'(prng_o), 64'(exp_w));
    tick();
    m_next(exp_w);
    chk("rs_word2", 64'(prng_o), 64'(exp_w));
    chk("rs_cnt", 64'(prng_cnt_o), 64'd1);
    reset = 1'b1;
    tick();
    chk_reset("rst_run");
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
